// File: rtl/wb_stage_if.sv
// MEM-to-WB bus: everything the memory stage hands to write-back each cycle.
interface wb_stage_if;
    logic        mem_wreg;
    logic        mem_m2reg;
    logic [31:0] mem_mdata;
    logic [31:0] mem_aluR;
    logic [4:0]  mem_destR;
    logic [3:0]  MEM_ins_type;
    logic [3:0]  MEM_ins_number;

    modport master (
        output mem_wreg, mem_m2reg, mem_mdata, mem_aluR, mem_destR,
               MEM_ins_type, MEM_ins_number
    );

    modport slave (
        input  mem_wreg, mem_m2reg, mem_mdata, mem_aluR, mem_destR,
               MEM_ins_type, MEM_ins_number
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, result select, 32x32 register file with
// write-through bypass to decode, and a retired-instruction counter.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_stage_if.slave        mem,
    input  logic [4:0]       id_rsA,
    input  logic [4:0]       id_rsB,
    output logic [31:0]      id_dataA,
    output logic [31:0]      id_dataB,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic             wb_wreg,
    output logic [4:0]       wb_destR,
    output logic [31:0]      wb_data,
    output logic [3:0]       WB_ins_type,
    output logic [3:0]       WB_ins_number,
    output logic [CNT_W-1:0] retired
);

    logic        wb_m2reg;
    logic [31:0] wb_mdata;
    logic [31:0] wb_aluR;
    logic [31:0] rf [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wreg       <= 1'b0;
            wb_m2reg      <= 1'b0;
            wb_mdata      <= '0;
            wb_aluR       <= '0;
            wb_destR      <= '0;
            WB_ins_type   <= '0;
            WB_ins_number <= '0;
        end else begin
            wb_wreg       <= mem.mem_wreg;
            wb_m2reg      <= mem.mem_m2reg;
            wb_mdata      <= mem.mem_mdata;
            wb_aluR       <= mem.mem_aluR;
            wb_destR      <= mem.mem_destR;
            WB_ins_type   <= mem.MEM_ins_type;
            WB_ins_number <= mem.MEM_ins_number;
        end
    end

    assign wb_data = wb_m2reg ? wb_mdata : wb_aluR;

    // rf[0] is only ever cleared, so it reads as zero without a special case.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_wreg && (wb_destR != 5'd0)) begin
            rf[wb_destR] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (WB_ins_type != 4'd0) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // The WB-resident value is the youngest, so it wins over the array.
    assign id_dataA = ((id_rsA != 5'd0) && wb_wreg && (wb_destR == id_rsA))
                      ? wb_data : rf[id_rsA];
    assign id_dataB = ((id_rsB != 5'd0) && wb_wreg && (wb_destR == id_rsB))
                      ? wb_data : rf[id_rsB];
    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized checks of wb_stage against a register-file level model.
module tb_wb_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rsA, id_rsB, dbg_addr;
    logic [31:0]      id_dataA, id_dataB, dbg_data, wb_data;
    logic             wb_wreg;
    logic [4:0]       wb_destR;
    logic [3:0]       WB_ins_type, WB_ins_number;
    logic [CNT_W-1:0] retired;

    wb_stage_if mem_bus ();

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mem_bus),
        .id_rsA        (id_rsA),
        .id_rsB        (id_rsB),
        .id_dataA      (id_dataA),
        .id_dataB      (id_dataB),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .wb_wreg       (wb_wreg),
        .wb_destR      (wb_destR),
        .wb_data       (wb_data),
        .WB_ins_type   (WB_ins_type),
        .WB_ins_number (WB_ins_number),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_check = 0;

    // Reference model: the instruction sitting in WB, the architectural registers, the count.
    logic        m_wreg, m_m2reg;
    logic [31:0] m_mdata, m_aluR;
    logic [4:0]  m_dest;
    logic [3:0]  m_type, m_num;
    logic [31:0] m_rf [32];
    int          m_ret;

    function automatic logic [31:0] modelWbData();
        return m_m2reg ? m_mdata : m_aluR;
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_wreg && m_dest == a) return modelWbData();
        return m_rf[a];
    endfunction

    task automatic modelReset();
        m_wreg = 0; m_m2reg = 0; m_mdata = 0; m_aluR = 0;
        m_dest = 0; m_type = 0; m_num = 0; m_ret = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_check++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one MEM-stage instruction, clocks it into WB and lands on the next falling edge.
    task automatic applyStimulus(input logic wreg, input logic m2reg, input logic [31:0] mdata,
                                 input logic [31:0] aluR, input logic [4:0] dest,
                                 input logic [3:0] itype, input logic [3:0] num);
        mem_bus.mem_wreg       = wreg;
        mem_bus.mem_m2reg      = m2reg;
        mem_bus.mem_mdata      = mdata;
        mem_bus.mem_aluR       = aluR;
        mem_bus.mem_destR      = dest;
        mem_bus.MEM_ins_type   = itype;
        mem_bus.MEM_ins_number = num;
        @(posedge clk);
        if (m_wreg && m_dest != 5'd0) m_rf[m_dest] = modelWbData();
        if (m_type != 4'd0) m_ret = (m_ret + 1) % (1 << CNT_W);
        m_wreg = wreg; m_m2reg = m2reg; m_mdata = mdata; m_aluR = aluR;
        m_dest = dest; m_type = itype; m_num = num;
        #2;
        // Load data moving after the capture edge must not reach wb_data.
        mem_bus.mem_mdata = $urandom;
        @(negedge clk);
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 4'd0, 4'd0);
    endtask

    task automatic checkAll(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        id_rsA = a; id_rsB = b; dbg_addr = d;
        #1;
        checkOutput("wb_wreg",   32'(wb_wreg),       32'(m_wreg));
        checkOutput("wb_destR",  32'(wb_destR),      32'(m_dest));
        checkOutput("wb_data",   wb_data,            modelWbData());
        checkOutput("WB_type",   32'(WB_ins_type),   32'(m_type));
        checkOutput("WB_number", 32'(WB_ins_number), 32'(m_num));
        checkOutput("retired",   32'(retired),       32'(m_ret));
        checkOutput("id_dataA",  id_dataA,           modelRead(a));
        checkOutput("id_dataB",  id_dataB,           modelRead(b));
        checkOutput("dbg_data",  dbg_data,           (d == 5'd0) ? 32'd0 : m_rf[d]);
    endtask

    // Drops reset between edges, checks the asynchronous clear, releases on a falling edge.
    task automatic pulseReset();
        #2;
        rst = 1'b0;
        modelReset();
        checkAll(5'd5, 5'd5, 5'd5);
        checkOutput("rst_dbg5",    dbg_data,       32'd0);
        checkOutput("rst_retired", 32'(retired),   32'd0);
        checkOutput("rst_wreg",    32'(wb_wreg),   32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] t;
        rst = 1'b0;
        id_rsA = 0; id_rsB = 0; dbg_addr = 0;
        mem_bus.mem_wreg = 0; mem_bus.mem_m2reg = 0; mem_bus.mem_mdata = 0;
        mem_bus.mem_aluR = 0; mem_bus.mem_destR = 0;
        mem_bus.MEM_ins_type = 0; mem_bus.MEM_ins_number = 0;
        modelReset();

        @(negedge clk);
        checkAll(5'd0, 5'd0, 5'd0);
        rst = 1'b1;

        // Preload r5, then lose it (and a pending write) to an asynchronous reset.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5, 4'd1, 4'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h5555, 5'd6, 4'd1, 4'd2);
        checkAll(5'd5, 5'd6, 5'd5);
        checkOutput("preload_r5", dbg_data, 32'h1234);
        pulseReset();
        checkAll(5'd6, 5'd5, 5'd6);

        // ALU write-back: bypass visible in the WB cycle, committed one edge later.
        applyStimulus(1'b1, 1'b0, $urandom, 32'hDEADBEEF, 5'd7, 4'd1, 4'd3);
        checkAll(5'd7, 5'd0, 5'd7);
        checkOutput("alu_wbdata", wb_data,  32'hDEADBEEF);
        checkOutput("alu_bypass", id_dataA, 32'hDEADBEEF);
        checkOutput("alu_dbgold", dbg_data, 32'h0);
        bubble();
        checkAll(5'd7, 5'd7, 5'd7);
        checkOutput("alu_commit",  dbg_data,     32'hDEADBEEF);
        checkOutput("alu_retired", 32'(retired), 32'd1);

        // Load select.
        applyStimulus(1'b1, 1'b1, 32'h0000_00AA, 32'h10, 5'd3, 4'd2, 4'd4);
        checkAll(5'd3, 5'd3, 5'd3);
        checkOutput("load_wbdata", wb_data, 32'hAA);
        bubble();
        checkAll(5'd3, 5'd1, 5'd3);
        checkOutput("load_commit", dbg_data, 32'hAA);

        // r0 ignores writes.
        applyStimulus(1'b1, 1'b0, $urandom, 32'hFFFF_FFFF, 5'd0, 4'd1, 4'd5);
        checkAll(5'd0, 5'd0, 5'd0);
        checkOutput("r0_bypass", id_dataA, 32'd0);
        bubble();
        checkAll(5'd0, 5'd0, 5'd0);
        checkOutput("r0_dbg", dbg_data, 32'd0);

        // Back-to-back writes to r4, then a bubble that must not count.
        applyStimulus(1'b1, 1'b0, $urandom, 32'd1, 5'd4, 4'd1, 4'd6);
        checkAll(5'd0, 5'd4, 5'd4);
        checkOutput("b2b_first", id_dataB, 32'd1);
        applyStimulus(1'b1, 1'b0, $urandom, 32'd2, 5'd4, 4'd1, 4'd7);
        checkAll(5'd4, 5'd4, 5'd4);
        checkOutput("b2b_second", id_dataB, 32'd2);
        checkOutput("b2b_commit1", dbg_data, 32'd1);
        bubble();
        checkAll(5'd4, 5'd4, 5'd4);
        bubble();
        checkAll(5'd4, 5'd4, 5'd4);
        checkOutput("b2b_final", dbg_data, 32'd2);

        // Counter wrap: 17 retirements on a 4-bit counter leave 1.
        pulseReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                          4'($urandom_range(1, 15)), 4'(i));
        end
        bubble();
        checkAll(5'($urandom), 5'($urandom), 5'($urandom));
        checkOutput("wrap_retired", 32'(retired), 32'd1);

        // Randomized traffic, bubbles roughly a quarter of the time.
        for (int i = 0; i < 80; i++) begin
            t = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom,
                          5'($urandom_range(0, 7)), t, 4'($urandom));
            checkAll(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
